// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer and its frame scheduler.
package piso_pkg;

   localparam int FRAME_W       = 16;  // bits per parallel frame
   localparam int SYM_W         = 2;   // bits per serial symbol
   localparam int SYM_PER_FRAME = 8;   // symbols shifted out per frame

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

endpackage : piso_pkg

// File: rtl/piso_sched_rr_arb2.sv
// Two-way round-robin arbiter. A grant is only issued while en_i is high,
// and every grant is a completed transfer, so the last-grant register
// updates on any grant.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   input  logic en_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   // 1: requester 1 won the last grant, so requester 0 wins the next tie.
   logic last1_q, last1_d;

   // Grant selection and next last-grant value.
   always_comb begin
      // NOTE: every combinational output gets a value on every path, so no latch is inferred.
      gnt0_o  = en_i & req0_i & (~req1_i |  last1_q);
      gnt1_o  = en_i & req1_i & (~req0_i | ~last1_q);
      last1_d = last1_q;
      if (gnt1_o) begin
         last1_d = 1'b1;
      end else if (gnt0_o) begin
         last1_d = 1'b0;
      end
   end

   // Last-grant register; reset pretends req1 went last so req0 is favoured first.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (rst) begin
         last1_q <= 1'b1;
      end else begin
         last1_q <= last1_d;
      end
   end

endmodule : rr_arb2

// File: rtl/piso_sched.sv
// Frame scheduler for a 2-bit-symbol PISO: arbitrates between two frame
// requesters, issues a one-cycle load strobe and then tracks the symbols
// being shifted out. The next frame can be accepted in the last shift
// cycle, giving a fixed 9-cycle frame period under continuous traffic.
module piso_sched #(
   parameter int FRAME_W       = piso_pkg::FRAME_W,
   parameter int SYM_PER_FRAME = piso_pkg::SYM_PER_FRAME
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid_i,
   input  logic [FRAME_W-1:0] req0_data_i,
   output logic               req0_ready_o,
   input  logic               req1_valid_i,
   input  logic [FRAME_W-1:0] req1_data_i,
   output logic               req1_ready_o,
   output logic               load_o,
   output logic [FRAME_W-1:0] data_parallel_o,
   output logic               src_id_o,
   output logic               busy_o,
   output logic [7:0]         frame_cnt_o
);

   import piso_pkg::*;

   localparam int               CNT_W    = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;
   localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYM_PER_FRAME - 1);

   state_e             state_q,     state_d;
   logic [CNT_W-1:0]   sym_cnt_q,   sym_cnt_d;
   logic               load_q,      load_d;
   logic [FRAME_W-1:0] data_q,      data_d;
   logic               src_q,       src_d;
   logic               busy_q,      busy_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;

   logic accept_window;
   logic gnt0;
   logic gnt1;
   logic xfer;

   // A frame may be taken while idle or in the final shift cycle; never during reset,
   // since the FSM is being cleared and the frame would be lost.
   assign accept_window = ~rst & ((state_q == ST_IDLE) |
                                  ((state_q == ST_SHIFT) & (sym_cnt_q == LAST_SYM)));

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req0_i (req0_valid_i),
      .req1_i (req1_valid_i),
      .en_i   (accept_window),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1)
   );

   assign xfer         = gnt0 | gnt1;
   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;

   // Next-state logic: FSM transitions, frame capture, symbol and frame counters.
   always_comb begin
      state_d     = state_q;
      sym_cnt_d   = sym_cnt_q;
      load_d      = 1'b0;
      data_d      = data_q;
      src_d       = src_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d   = ST_SHIFT;
            sym_cnt_d = '0;
         end
         ST_SHIFT: begin
            if (sym_cnt_q == LAST_SYM) begin
               state_d = xfer ? ST_LOAD : ST_IDLE;
            end else begin
               sym_cnt_d = sym_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Any accepted frame is captured here and strobed out on the following cycle.
      if (xfer) begin
         load_d      = 1'b1;
         data_d      = gnt1 ? req1_data_i : req0_data_i;
         src_d       = gnt1;
         frame_cnt_d = frame_cnt_q + 8'd1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset drops any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sym_cnt_q   <= '0;
         load_q      <= 1'b0;
         data_q      <= '0;
         src_q       <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         sym_cnt_q   <= sym_cnt_d;
         load_q      <= load_d;
         data_q      <= data_d;
         src_q       <= src_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign load_o          = load_q;
   assign data_parallel_o = data_q;
   assign src_id_o        = src_q;
   assign busy_o          = busy_q;
   assign frame_cnt_o     = frame_cnt_q;

endmodule : piso_sched

// File: tb/tb_piso_sched.sv
// Directed bench for piso_sched: frames are pushed to a scoreboard in the
// order the round-robin rule says they must be issued, and popped on load_o.
module tb_piso_sched;

   localparam int FW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid_i, req1_valid_i;
   logic [FW-1:0] req0_data_i,  req1_data_i;
   logic          req0_ready_o, req1_ready_o;
   logic          load_o;
   logic [FW-1:0] data_parallel_o;
   logic          src_id_o;
   logic          busy_o;
   logic [7:0]    frame_cnt_o;

   typedef struct {
      logic          src;
      logic [FW-1:0] data;
   } frame_t;

   frame_t sb[$];
   frame_t mon_f;
   int     checks   = 0;
   int     failures = 0;
   int     cyc      = 0;
   logic   prev_load = 1'b0;

   piso_sched #(.FRAME_W(FW), .SYM_PER_FRAME(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .req0_valid_i    (req0_valid_i),
      .req0_data_i     (req0_data_i),
      .req0_ready_o    (req0_ready_o),
      .req1_valid_i    (req1_valid_i),
      .req1_data_i     (req1_data_i),
      .req1_ready_o    (req1_ready_o),
      .load_o          (load_o),
      .data_parallel_o (data_parallel_o),
      .src_id_o        (src_id_o),
      .busy_o          (busy_o),
      .frame_cnt_o     (frame_cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance at least one cycle, then up to a bounded number more, until load_o.
   task automatic wait_load(input string tag);
      int n;
      n = 0;
      tick();
      while (load_o !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_seen"}, 32'(load_o), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy_o !== 1'b0 && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 32'(busy_o), 32'd0);
   endtask

   // Scoreboard pop on every load strobe plus protocol invariants every cycle.
   always @(negedge clk) begin
      check("one_ready", 32'(req0_ready_o & req1_ready_o), 32'd0);
      check("load_back_to_back", 32'(load_o & prev_load), 32'd0);
      prev_load <= load_o;
      if (load_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_f = sb.pop_front();
            check("sb_src", 32'(src_id_o), 32'(mon_f.src));
            check("sb_data", 32'(data_parallel_o), 32'(mon_f.data));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_n;
      int last_load_cyc;
      int l_cyc;

      // Reset state
      rst = 1'b1;
      req0_valid_i = 1'b0; req0_data_i = '0;
      req1_valid_i = 1'b0; req1_data_i = '0;
      tick(); tick();
      check("rst_load",  32'(load_o),          32'd0);
      check("rst_busy",  32'(busy_o),          32'd0);
      check("rst_src",   32'(src_id_o),        32'd0);
      check("rst_cnt",   32'(frame_cnt_o),     32'd0);
      check("rst_data",  32'(data_parallel_o), 32'd0);
      check("rst_rdy0",  32'(req0_ready_o),    32'd0);
      check("rst_rdy1",  32'(req1_ready_o),    32'd0);

      // Single frame from req0
      rst = 1'b0;
      req0_valid_i = 1'b1; req0_data_i = 16'hA5A5;
      sb.push_back('{1'b0, 16'hA5A5});
      #1;
      check("single_rdy0", 32'(req0_ready_o), 32'd1);
      check("single_rdy1", 32'(req1_ready_o), 32'd0);
      tick();
      req0_valid_i = 1'b0;
      check("single_load", 32'(load_o),          32'd1);
      check("single_data", 32'(data_parallel_o), 32'h0000A5A5);
      check("single_cnt",  32'(frame_cnt_o),     32'd1);
      check("single_rdy_in_load", 32'(req0_ready_o), 32'd0);
      busy_n = 0;
      while (busy_o === 1'b1 && busy_n < 20) begin
         busy_n++;
         tick();
      end
      check("single_busy_cycles", 32'(busy_n), 32'd9);
      check("single_data_hold", 32'(data_parallel_o), 32'h0000A5A5);
      check("single_cnt_hold",  32'(frame_cnt_o),     32'd1);

      // Contention after a fresh reset: grants 0,1,0,1, loads 9 cycles apart
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid_i = 1'b1; req0_data_i = 16'h1111;
      req1_valid_i = 1'b1; req1_data_i = 16'hFFFF;
      sb.push_back('{1'b0, 16'h1111});
      sb.push_back('{1'b1, 16'hFFFF});
      sb.push_back('{1'b0, 16'h1111});
      sb.push_back('{1'b1, 16'hFFFF});
      last_load_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         wait_load("cont_load");
         check("cont_src", 32'(src_id_o), 32'(k % 2));
         if (k > 0) check("cont_period", 32'(cyc - last_load_cyc), 32'd9);
         last_load_cyc = cyc;
      end
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      check("cont_cnt", 32'(frame_cnt_o), 32'd4);
      wait_idle("cont");

      // Mid-frame request from req1 arriving in shift count 3
      req0_valid_i = 1'b1; req0_data_i = 16'h1234;
      sb.push_back('{1'b0, 16'h1234});
      tick();
      req0_valid_i = 1'b0;
      check("mid_load0", 32'(load_o), 32'd1);
      l_cyc = cyc;
      tick(); tick(); tick(); tick();
      req1_valid_i = 1'b1; req1_data_i = 16'hBEEF;
      sb.push_back('{1'b1, 16'hBEEF});
      #1;
      check("mid_rdy_c3", 32'(req1_ready_o), 32'd0);
      for (int c = 4; c < 7; c++) begin
         tick();
         check("mid_rdy_held", 32'(req1_ready_o), 32'd0);
      end
      tick();
      check("mid_rdy_c7", 32'(req1_ready_o), 32'd1);
      tick();
      req1_valid_i = 1'b0;
      check("mid_load1", 32'(load_o), 32'd1);
      check("mid_gapless", 32'(cyc - l_cyc), 32'd9);
      check("mid_busy", 32'(busy_o), 32'd1);
      wait_idle("mid");

      // Reset in shift count 4 with a req0 frame pending
      req1_valid_i = 1'b1; req1_data_i = 16'h5555;
      sb.push_back('{1'b1, 16'h5555});
      tick();
      req1_valid_i = 1'b0;
      check("rstmid_load", 32'(load_o), 32'd1);
      tick(); tick(); tick(); tick(); tick();
      rst = 1'b1;
      req0_valid_i = 1'b1; req0_data_i = 16'h0F0F;
      req1_valid_i = 1'b1; req1_data_i = 16'h7777;
      tick();
      check("rstmid_load0",  32'(load_o),          32'd0);
      check("rstmid_busy",   32'(busy_o),          32'd0);
      check("rstmid_src",    32'(src_id_o),        32'd0);
      check("rstmid_cnt",    32'(frame_cnt_o),     32'd0);
      check("rstmid_data",   32'(data_parallel_o), 32'd0);
      check("rstmid_rdy0",   32'(req0_ready_o),    32'd0);
      check("rstmid_rdy1",   32'(req1_ready_o),    32'd0);
      rst = 1'b0;
      sb.push_back('{1'b0, 16'h0F0F});
      #1;
      check("rstmid_favour0", 32'(req0_ready_o), 32'd1);
      check("rstmid_not1",    32'(req1_ready_o), 32'd0);
      tick();
      req0_valid_i = 1'b0;
      check("rstmid_reload", 32'(load_o), 32'd1);
      sb.push_back('{1'b1, 16'h7777});
      wait_load("rstmid_second");
      req1_valid_i = 1'b0;
      check("rstmid_src1", 32'(src_id_o),    32'd1);
      check("rstmid_cnt2", 32'(frame_cnt_o), 32'd2);
      wait_idle("rstmid");

      // Frame counter wrap: 254 more frames take the count from 2 through 255 to 0
      req0_valid_i = 1'b1; req0_data_i = 16'h1000;
      sb.push_back('{1'b0, 16'h1000});
      for (int i = 0; i < 254; i++) begin
         wait_load("wrap_load");
         if (i == 252) check("wrap_255", 32'(frame_cnt_o), 32'd255);
         if (i == 253) check("wrap_0",   32'(frame_cnt_o), 32'd0);
         if (i < 253) begin
            req0_data_i = 16'(16'h1000 + i + 1);
            sb.push_back('{1'b0, 16'(16'h1000 + i + 1)});
         end else begin
            req0_valid_i = 1'b0;
         end
      end
      wait_idle("wrap");
      check("wrap_cnt_hold", 32'(frame_cnt_o), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_piso_sched
